uart_tx_fifo: RTL and testbench

//  8N1 UART transmitter with a byte FIFO on its input. It drives the SoC serial TX pin that the

---
 rtl/uart_tx_fifo.sv | 144 ++++++++++++++
 tb/tb_uart_tx_fifo.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: 8N1 UART transmitter fed by a byte FIFO.
// Ports: clk, rst (sync, active high), tx_data_i/tx_valid_i/tx_ready_o push port,
//        fifo_count_o (queued bytes), busy_o (frame on line or FIFO non-empty), TX (idle high).
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 5208,
    parameter int FIFO_DEPTH   = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [7:0]                  tx_data_i,
    input  logic                        tx_valid_i,
    output logic                        tx_ready_o,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count_o,
    output logic                        busy_o,
    output logic                        TX
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [AW:0]   FULL     = (AW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t        state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [2:0]    idx_q, idx_d;
    logic [7:0]    shift_q, shift_d;
    logic          tx_q, tx_d;

    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wptr_q, rptr_q;
    logic [AW:0]   count_q;
    logic          push, pop, bit_done;

    // Ready comes from the registered count only, so a pop in the
    // same cycle never opens a slot for a push into a full FIFO.
    assign tx_ready_o   = count_q < FULL;
    assign push         = tx_valid_i & tx_ready_o;
    assign bit_done     = cnt_q == BIT_LAST;
    assign fifo_count_o = count_q;
    assign busy_o       = (state_q != IDLE) | (count_q != '0);
    assign TX           = tx_q;

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wptr_q] <= tx_data_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                wptr_q <= wptr_q + 1'b1;
            end
            if (pop) begin
                rptr_q <= rptr_q + 1'b1;
            end
            case ({push, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            tx_q    <= tx_d;
        end
    end

    // tx_d is the level for the current state; registering it delays
    // every bit by one cycle but keeps TX glitch-free.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        idx_d   = idx_q;
        shift_d = shift_q;
        tx_d    = 1'b1;
        pop     = 1'b0;
        unique case (state_q)
            IDLE: begin
                cnt_d = '0;
                if (count_q != '0) begin
                    pop     = 1'b1;
                    shift_d = mem[rptr_q];
                    state_d = START;
                end
            end
            START: begin
                tx_d = 1'b0;
                if (bit_done) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = DATA;
                end
            end
            DATA: begin
                tx_d = shift_q[0];
                if (bit_done) begin
                    cnt_d   = '0;
                    shift_d = {1'b0, shift_q[7:1]};
                    idx_d   = idx_q + 3'd1;
                    if (idx_q == 3'd7) begin
                        state_d = STOP;
                    end
                end
            end
            STOP: begin
                if (bit_done) begin
                    cnt_d = '0;
                    // Chain straight into the next start bit when data waits.
                    if (count_q != '0) begin
                        pop     = 1'b1;
                        shift_d = mem[rptr_q];
                        state_d = START;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_uart_tx_fifo.sv
// tb_uart_tx_fifo: scoreboard bench for uart_tx_fifo.
// Bytes go into a queue on accept; an RX monitor decodes TX and compares.
module tb_uart_tx_fifo;
    localparam int CPB   = 4;
    localparam int DEPTH = 4;
    localparam int FLEN  = 10 * CPB;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_ready;
    logic [2:0] fifo_count;
    logic       busy;
    logic       TX;

    uart_tx_fifo #(
        .CLKS_PER_BIT(CPB),
        .FIFO_DEPTH  (DEPTH)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .tx_data_i   (tx_data),
        .tx_valid_i  (tx_valid),
        .tx_ready_o  (tx_ready),
        .fifo_count_o(fifo_count),
        .busy_o      (busy),
        .TX          (TX)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int frames_done = 0;
    logic [7:0] sbq[$];
    int starts[$];

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #300000;
        $display("FAIL watchdog: simulation did not finish, cyc=%0d", cyc);
        $fatal(1);
    end

    // RX monitor: one sample per cycle; each bit must hold for CPB samples.
    logic [FLEN-1:0] mon_s;
    logic            mon_prev = 1'b1;
    bit              mon_abort;
    bit              mon_ok;
    logic [7:0]      mon_byte;
    logic [7:0]      mon_exp;

    always begin
        @(negedge clk);
        if (!rst && mon_prev === 1'b1 && TX === 1'b0) begin
            starts.push_back(cyc);
            mon_s     = '0;
            mon_s[0]  = TX;
            mon_abort = 1'b0;
            for (int k = 1; k < FLEN; k++) begin
                @(negedge clk);
                if (rst) begin
                    mon_abort = 1'b1;
                    break;
                end
                mon_s[k] = TX;
            end
            if (!mon_abort) begin
                mon_ok = 1'b1;
                for (int b = 0; b < 10; b++)
                    for (int j = 1; j < CPB; j++)
                        if (mon_s[b*CPB+j] !== mon_s[b*CPB]) mon_ok = 1'b0;
                if (mon_s[0] !== 1'b0 || mon_s[9*CPB] !== 1'b1) mon_ok = 1'b0;
                for (int i = 0; i < 8; i++) mon_byte[i] = mon_s[(i+1)*CPB];
                checks++;
                if (!mon_ok) begin
                    errors++;
                    $display("FAIL framing: samples=%h", mon_s);
                end
                checks++;
                if (sbq.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_frame: got %h, required none", mon_byte);
                end else begin
                    mon_exp = sbq.pop_front();
                    if (mon_byte !== mon_exp) begin
                        errors++;
                        $display("FAIL rx_byte: got %h, required %h", mon_byte, mon_exp);
                    end
                end
                frames_done++;
                mon_prev = mon_s[FLEN-1];
            end else begin
                mon_prev = 1'b1;
            end
        end else begin
            mon_prev = TX;
        end
    end

    // Called at a negedge; returns at the negedge after the accepting edge.
    task automatic push_byte(input logic [7:0] b, output int acc, output int stall);
        stall    = 0;
        tx_data  = b;
        tx_valid = 1'b1;
        while (tx_ready !== 1'b1 && stall < 400) begin
            @(negedge clk);
            stall++;
        end
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL push_accept: byte %h not accepted, ready=%b", b, tx_ready);
            tx_valid = 1'b0;
            acc = cyc;
            return;
        end
        sbq.push_back(b);
        @(negedge clk);
        acc      = cyc;
        tx_valid = 1'b0;
    endtask

    task automatic wait_cyc(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic wait_frames(input int target, input int budget);
        int n;
        n = 0;
        while (frames_done < target && n < budget) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (frames_done < target) begin
            errors++;
            $display("FAIL frame_timeout: frames=%0d, required %0d", frames_done, target);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        checks += 4;
        if (TX !== 1'b1) begin errors++; $display("FAIL rst_tx: got %b, required 1", TX); end
        if (tx_ready !== 1'b1) begin errors++; $display("FAIL rst_ready: got %b, required 1", tx_ready); end
        if (busy !== 1'b0) begin errors++; $display("FAIL rst_busy: got %b, required 0", busy); end
        if (fifo_count !== 3'd0) begin errors++; $display("FAIL rst_count: got %0d, required 0", fifo_count); end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_single;
        int n, s, f0, b0;
        f0 = frames_done;
        b0 = starts.size();
        push_byte(8'h55, n, s);
        wait_cyc(n + 1);
        checks++;
        if (TX !== 1'b1) begin errors++; $display("FAIL single_tx_n1: got %b, required 1", TX); end
        wait_cyc(n + 2);
        checks += 2;
        if (TX !== 1'b0) begin errors++; $display("FAIL single_tx_fall: got %b, required 0", TX); end
        if (busy !== 1'b1) begin errors++; $display("FAIL single_busy: got %b, required 1", busy); end
        wait_cyc(n + 40);
        checks++;
        if (busy !== 1'b1) begin errors++; $display("FAIL single_busy_stop: got %b, required 1", busy); end
        wait_cyc(n + 41);
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL single_busy_end: got %b, required 0", busy); end
        wait_frames(f0 + 1, 20);
        checks++;
        if (starts.size() <= b0 || starts[b0] != n + 2) begin
            errors++;
            $display("FAIL single_start: got start list size %0d, required start at %0d", starts.size(), n + 2);
        end
    endtask

    task automatic test_back_to_back;
        int n1, n2, s, f0, b0;
        f0 = frames_done;
        b0 = starts.size();
        push_byte(8'h41, n1, s);
        push_byte(8'h42, n2, s);
        checks += 2;
        if (n2 != n1 + 1) begin errors++; $display("FAIL b2b_accept: got %0d, required %0d", n2, n1 + 1); end
        if (fifo_count !== 3'd1) begin errors++; $display("FAIL b2b_count: got %0d, required 1", fifo_count); end
        wait_frames(f0 + 2, 120);
        checks++;
        if (starts.size() < b0 + 2 || starts[b0+1] - starts[b0] != FLEN) begin
            errors++;
            $display("FAIL b2b_gap: starts=%p, required spacing %0d", starts, FLEN);
        end
        checks++;
        if (busy !== 1'b0) begin errors++; $display("FAIL b2b_idle: got busy %b, required 0", busy); end
    endtask

    task automatic test_full;
        int n, s, f0;
        f0 = frames_done;
        for (int i = 1; i <= 5; i++) push_byte(8'(i), n, s);
        checks += 2;
        if (tx_ready !== 1'b0) begin errors++; $display("FAIL full_ready: got %b, required 0", tx_ready); end
        if (fifo_count !== 3'd4) begin errors++; $display("FAIL full_count: got %0d, required 4", fifo_count); end
        push_byte(8'h06, n, s);
        checks += 2;
        if (s < 1) begin errors++; $display("FAIL full_stall: got %0d stall cycles, required >0", s); end
        if (fifo_count !== 3'd4) begin errors++; $display("FAIL full_refill: got %0d, required 4", fifo_count); end
        wait_frames(f0 + 6, 6 * FLEN + 60);
    endtask

    task automatic test_reset_mid;
        int n, s, f0, lows;
        f0 = frames_done;
        push_byte(8'hA5, n, s);
        push_byte(8'h11, s, s);
        push_byte(8'h22, s, s);
        wait_cyc(n + 19);
        rst = 1'b1;
        @(negedge clk);
        checks += 4;
        if (TX !== 1'b1) begin errors++; $display("FAIL mid_rst_tx: got %b, required 1", TX); end
        if (fifo_count !== 3'd0) begin errors++; $display("FAIL mid_rst_count: got %0d, required 0", fifo_count); end
        if (busy !== 1'b0) begin errors++; $display("FAIL mid_rst_busy: got %b, required 0", busy); end
        if (tx_ready !== 1'b1) begin errors++; $display("FAIL mid_rst_ready: got %b, required 1", tx_ready); end
        rst = 1'b0;
        sbq.delete();
        lows = 0;
        repeat (150) begin
            @(negedge clk);
            if (TX !== 1'b1) lows++;
        end
        checks += 2;
        if (lows != 0) begin errors++; $display("FAIL mid_rst_quiet: got %0d low cycles, required 0", lows); end
        if (frames_done != f0) begin errors++; $display("FAIL mid_rst_frames: got %0d, required %0d", frames_done, f0); end
    endtask

    task automatic test_stop_pop;
        int n, n3, s, f0, b0;
        f0 = frames_done;
        b0 = starts.size();
        push_byte(8'h61, n, s);
        push_byte(8'h62, s, s);
        wait_cyc(n + 40);
        push_byte(8'h63, n3, s);
        checks += 2;
        if (n3 != n + 41) begin errors++; $display("FAIL stop_pop_accept: got %0d, required %0d", n3, n + 41); end
        if (fifo_count !== 3'd1) begin errors++; $display("FAIL stop_pop_count: got %0d, required 1", fifo_count); end
        wait_frames(f0 + 3, 3 * FLEN + 20);
        checks++;
        if (starts.size() < b0 + 2 || starts[b0+1] - starts[b0] != FLEN) begin
            errors++;
            $display("FAIL stop_pop_gap: starts=%p, required spacing %0d", starts, FLEN);
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_back_to_back();
        test_full();
        test_reset_mid();
        test_stop_pop();
        repeat (10) @(negedge clk);
        checks++;
        if (sbq.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d pending bytes, required 0", sbq.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
